instr_mem_responder: RTL and testbench
======================================

# instr_mem_responder

Responder end of the instruction-fetch bus (req/gnt/addr/rdata/err/rvalid): accepts fetch requests from the fetch stage and returns 32-bit instruction words from an internal word-addressed memory. Grant wait states are runtime-programmable and response latency is a fixed parameter, so the fetch stall/bubble logic can be exercised against realistic memory timing. A side load port preloads program images. Used in core-level simulation and as the FPGA boot/instruction RAM.

## Interface
- DEPTH_WORDS, 4096: memory size in 32-bit words (power of two, ≥ 4)
- BASE_ADDR, 32'h0000_0000: byte address of word 0 (aligned to 4*DEPTH_WORDS)
- RESP_LATENCY, 1: cycles from grant to rvalid (1..4)
- MAX_OUTSTANDING, 2: granted-but-unanswered requests allowed (1..RESP_LATENCY+1)

- clk  in  1  clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- instr_req_i  in  1  request; held with stable addr until granted
- instr_addr_i  in  32  byte address of requested instruction
- instr_gnt_o  out  1  grant; handshake = req & gnt in same cycle
- instr_rvalid_o  out  1  response valid, exactly one pulse per handshake, in order
- instr_rdata_o  out  32  instruction word, valid while rvalid
- instr_err_o  out  1  error response, valid while rvalid
- wait_cycles_i  in  4  grant wait states (0 = same-cycle grant)
- load_we_i  in  1  preload write strobe
- load_addr_i  in  32  preload byte address (bits [1:0] ignored)
- load_wdata_i  in  32  preload data
- proto_err_o  out  1  sticky: requester dropped req while waiting for grant

## Operation
- Grant FSM, states IDLE, WAIT.
  - IDLE: req=1, not full, wait_cycles_i=0 → gnt=1 combinationally this cycle, stay IDLE.
  - IDLE: req=1, wait_cycles_i=W>0 → load cnt=W-1, go WAIT, gnt=0. wait_cycles_i sampled only here.
  - WAIT: cnt≠0 → cnt-1. cnt=0 and not full → gnt=1, go IDLE. cnt=0 and full → hold WAIT until not full.
  - WAIT: req=0 → go IDLE, set proto_err_o, no grant.
- full = (outstanding == MAX_OUTSTANDING) & !instr_rvalid_o; a retiring response frees its slot in the same cycle.
- outstanding: +1 on handshake, -1 on rvalid; both in one cycle → unchanged. Never exceeds MAX_OUTSTANDING or underflows.
- Handshake: compute word index (addr-BASE_ADDR)>>2; err if addr[1:0]≠0 or addr outside [BASE_ADDR, BASE_ADDR+4*DEPTH_WORDS). Push {err, rdata} into RESP_LATENCY-deep shift pipeline; error entries carry rdata=0.
- Memory read is synchronous at handshake; pipeline output drives rvalid/rdata/err registered. rdata/err are 0 when rvalid=0.
- Load port: load_we_i writes mem[(load_addr_i-BASE_ADDR)>>2] at clk edge; out-of-range load writes are dropped. Same-cycle load write and handshake read of the same word returns OLD data.
- Memory contents are not reset; reset clears only control and pipeline.

## Timing
- Reset values: instr_gnt_o=0 (forced 0 while rstn=0), instr_rvalid_o=0, instr_rdata_o=0, instr_err_o=0, proto_err_o=0, FSM=IDLE, cnt=0, outstanding=0.
- Grant latency: W cycles after req first seen in IDLE (W=0: same cycle), plus any full-stall cycles.
- Response latency: rvalid exactly RESP_LATENCY cycles after the handshake edge; back-to-back handshakes give back-to-back rvalid.
- Throughput with W=0, MAX_OUTSTANDING ≥ RESP_LATENCY: one handshake per cycle.
- Reset asserted mid-transaction: all in-flight responses discarded, no rvalid after release; first post-reset request behaves as from IDLE.
- proto_err_o cleared only by reset.

## Test plan
- Preload mem[0..3]=0x00000013,0x00100093,0x00200113,0x00300193; W=0, latency 1, req addrs 0,4,8,12 consecutively → gnt every cycle, rvalid cycles 1..4 with those words, err=0.
- W=3: req addr 0x8 at cycle 0 → gnt at cycle 3 only, rvalid at cycle 4 with 0x00200113; change wait_cycles_i to 0 at cycle 1 → no effect on this request.
- Misaligned 0x6 and out-of-range BASE_ADDR+4*DEPTH_WORDS → granted, rvalid with err=1, rdata=0; next in-range request err=0.
- RESP_LATENCY=3, MAX_OUTSTANDING=1, continuous req → gnt once per 3 cycles (gnt in the rvalid cycle), outstanding never >1.
- Load write 0xDEADBEEF to word 5 same cycle as handshake on 0x14 → rvalid returns old word; next read returns 0xDEADBEEF.
- W=4, drop req after 2 cycles → no gnt, proto_err_o=1 and stays 1; assert rstn=0 with 2 responses in flight → no rvalid after release, proto_err_o=0.

Source files
------------

// File: rtl/instr_mem_responder.sv
// Instruction-fetch bus responder: programmable grant wait states, fixed-latency
// in-order responses from a word-addressed RAM, plus a side preload port.
module instr_mem_responder #(
  parameter int          DEPTH_WORDS     = 4096,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          RESP_LATENCY    = 1,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic [3:0]  wait_cycles_i,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_wdata_i,
  output logic        proto_err_o
);
  localparam int          AW      = $clog2(DEPTH_WORDS);
  localparam int          OW      = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [32:0] SPAN    = 33'(DEPTH_WORDS) << 2;
  localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

  typedef enum logic {S_IDLE, S_WAIT} state_e;
  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } resp_t;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic [OW-1:0]           out_q;
  logic                    proto_err_q;
  logic [RESP_LATENCY-1:0] vld_pipe_q;
  resp_t                   pipe_q [RESP_LATENCY];
  logic [31:0]             mem [DEPTH_WORDS];

  logic          full, gnt, hs;
  logic [31:0]   rd_off, ld_off;
  logic          rd_err, ld_ok;
  logic [AW-1:0] rd_idx, ld_idx;

  // A response retiring this cycle frees its slot for a same-cycle grant.
  assign full = (out_q == MAX_OUT) && !vld_pipe_q[RESP_LATENCY-1];

  always_comb begin
    gnt = 1'b0;
    if (rstn && instr_req_i && !full) begin
      if (state_q == S_IDLE) gnt = (wait_cycles_i == 4'd0);
      else                   gnt = (cnt_q == 4'd0);
    end
  end

  assign hs     = instr_req_i & gnt;
  assign rd_off = instr_addr_i - BASE_ADDR;
  assign rd_idx = rd_off[AW+1:2];
  // Addresses below the base wrap to large offsets and fail the span check.
  assign rd_err = (instr_addr_i[1:0] != 2'b00) || ({1'b0, rd_off} >= SPAN);
  assign ld_off = load_addr_i - BASE_ADDR;
  assign ld_idx = ld_off[AW+1:2];
  assign ld_ok  = ({1'b0, ld_off} < SPAN);

  always_ff @(posedge clk) begin
    if (load_we_i && ld_ok) mem[ld_idx] <= load_wdata_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      proto_err_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (instr_req_i && wait_cycles_i != 4'd0) begin
            cnt_q   <= wait_cycles_i - 4'd1;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!instr_req_i) begin
            state_q     <= S_IDLE;
            proto_err_q <= 1'b1;
          end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else if (!full) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                         out_q <= '0;
    else if (hs && !instr_rvalid_o)    out_q <= out_q + OW'(1);
    else if (!hs && instr_rvalid_o)    out_q <= out_q - OW'(1);
  end

  // Read happens at the handshake edge; old data wins over a same-edge load.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe_q <= '0;
      for (int i = 0; i < RESP_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      vld_pipe_q[0] <= hs;
      pipe_q[0]     <= '0;
      if (hs) pipe_q[0] <= '{err: rd_err, data: rd_err ? 32'h0 : mem[rd_idx]};
      for (int i = 1; i < RESP_LATENCY; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        pipe_q[i]     <= pipe_q[i-1];
      end
    end
  end

  assign instr_gnt_o    = gnt;
  assign instr_rvalid_o = vld_pipe_q[RESP_LATENCY-1];
  assign instr_rdata_o  = pipe_q[RESP_LATENCY-1].data;
  assign instr_err_o    = pipe_q[RESP_LATENCY-1].err;
  assign proto_err_o    = proto_err_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: two instances (default timing, and latency 3 /
// one outstanding at a non-zero base), directed vectors plus a per-cycle model.
module tb_instr_mem_responder;
  localparam logic [31:0] B1 = 32'h1000_0000;

  logic clk = 1'b0;
  logic rstn;
  logic [1:0]       req, gnt, rv, er, pe, lwe;
  logic [1:0][31:0] addr, rd, laddr, lwd;
  logic [1:0][3:0]  wt;
  int total = 0, bad = 0, cyc = 0;

  always #5 clk = ~clk;

  instr_mem_responder #(.DEPTH_WORDS(4096), .BASE_ADDR(32'h0), .RESP_LATENCY(1), .MAX_OUTSTANDING(2)) u0 (
    .clk(clk), .rstn(rstn), .instr_req_i(req[0]), .instr_addr_i(addr[0]), .instr_gnt_o(gnt[0]),
    .instr_rvalid_o(rv[0]), .instr_rdata_o(rd[0]), .instr_err_o(er[0]), .wait_cycles_i(wt[0]),
    .load_we_i(lwe[0]), .load_addr_i(laddr[0]), .load_wdata_i(lwd[0]), .proto_err_o(pe[0]));

  instr_mem_responder #(.DEPTH_WORDS(64), .BASE_ADDR(B1), .RESP_LATENCY(3), .MAX_OUTSTANDING(1)) u1 (
    .clk(clk), .rstn(rstn), .instr_req_i(req[1]), .instr_addr_i(addr[1]), .instr_gnt_o(gnt[1]),
    .instr_rvalid_o(rv[1]), .instr_rdata_o(rd[1]), .instr_err_o(er[1]), .wait_cycles_i(wt[1]),
    .load_we_i(lwe[1]), .load_addr_i(laddr[1]), .load_wdata_i(lwd[1]), .proto_err_o(pe[1]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", nm, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input logic act, input logic exp);
    chk(nm, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic peek();
    @(negedge clk); #1;
  endtask

  function automatic logic [31:0] base_of(input int d);  return (d == 0) ? 32'h0 : B1; endfunction
  function automatic int depth_of(input int d);           return (d == 0) ? 4096 : 64; endfunction
  function automatic int lat_of(input int d);             return (d == 0) ? 1 : 3;     endfunction
  function automatic int mx_of(input int d);              return (d == 0) ? 2 : 1;     endfunction

  // Model: responses are queued with the cycle they are due; a grant is owed once
  // the request has waited its latched W cycles and a response slot is free.
  typedef struct {
    int          dut;
    int          due;
    bit          err;
    logic [31:0] data;
    bit          known;
  } rsp_t;
  rsp_t        rq[$];
  logic [31:0] mm [2][4096];
  bit          kn [2][4096];
  int          mout[2], el[2], lw[2];
  bit          pend[2], mpe[2];

  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        int qi;
        bit due, eg, e;
        logic [31:0] off;
        rsp_t r;
        if (!rstn) begin
          chkb($sformatf("d%0d c%0d rst gnt", d, cyc), gnt[d], 1'b0);
          chkb($sformatf("d%0d c%0d rst rvalid", d, cyc), rv[d], 1'b0);
          chk($sformatf("d%0d c%0d rst rdata", d, cyc), rd[d], 32'h0);
          chkb($sformatf("d%0d c%0d rst err", d, cyc), er[d], 1'b0);
          chkb($sformatf("d%0d c%0d rst proto", d, cyc), pe[d], 1'b0);
          for (int i = rq.size() - 1; i >= 0; i--) if (rq[i].dut == d) rq.delete(i);
          mout[d] = 0; pend[d] = 0; el[d] = 0; lw[d] = 0; mpe[d] = 0;
        end else begin
          qi = -1;
          for (int i = 0; i < rq.size(); i++) if (rq[i].dut == d) begin qi = i; break; end
          due = (qi >= 0) && (rq[qi].due == cyc);
          chkb($sformatf("d%0d c%0d rvalid", d, cyc), rv[d], due);
          if (due) begin
            chkb($sformatf("d%0d c%0d err", d, cyc), er[d], rq[qi].err);
            if (rq[qi].known) chk($sformatf("d%0d c%0d rdata", d, cyc), rd[d], rq[qi].data);
          end else begin
            chk($sformatf("d%0d c%0d idle rdata", d, cyc), rd[d], 32'h0);
            chkb($sformatf("d%0d c%0d idle err", d, cyc), er[d], 1'b0);
          end
          eg = 1'b0;
          if (req[d]) begin
            if (!pend[d]) begin pend[d] = 1; el[d] = 0; lw[d] = int'(wt[d]); end
            eg = (el[d] >= lw[d]) && ((mout[d] < mx_of(d)) || due);
          end
          chkb($sformatf("d%0d c%0d gnt", d, cyc), gnt[d], eg);
          chkb($sformatf("d%0d c%0d proto", d, cyc), pe[d], mpe[d]);
          if (due) begin rq.delete(qi); mout[d]--; end
          if (eg) begin
            off = addr[d] - base_of(d);
            e = (addr[d][1:0] != 2'b00) || (off >= 32'(4 * depth_of(d)));
            r.dut = d; r.due = cyc + lat_of(d); r.err = e;
            if (e) begin r.data = 32'h0; r.known = 1; end
            else   begin r.data = mm[d][off >> 2]; r.known = kn[d][off >> 2]; end
            rq.push_back(r);
            mout[d]++;
            pend[d] = 0;
          end else if (req[d]) begin
            el[d]++;
          end
          if (!req[d]) begin
            if (pend[d] && lw[d] > 0) mpe[d] = 1;
            pend[d] = 0;
          end
          if (lwe[d]) begin
            off = laddr[d] - base_of(d);
            if (off < 32'(4 * depth_of(d))) begin mm[d][off >> 2] = lwd[d]; kn[d][off >> 2] = 1; end
          end
        end
      end
      cyc++;
    end
  end

  logic [31:0] pre0 [6] = '{32'h00000013, 32'h00100093, 32'h00200113, 32'h00300193, 32'h44444444, 32'h55555555};
  logic [31:0] pre1 [4] = '{32'hA0000000, 32'hA0000001, 32'hA0000002, 32'hA0000003};
  logic [31:0] a3 [3]   = '{32'h6, 32'h4000, 32'hC};
  logic [31:0] a4 [5]   = '{B1, B1 - 32'd4, B1 + 32'd252, B1 + 32'h100, B1 + 32'd4};
  logic [31:0] rd4 [5]  = '{32'hA0000000, 32'h0, 32'hB000003F, 32'h0, 32'hA0000001};
  logic        er4 [5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [31:0] a5 [5]   = '{32'h14, 32'h14, 32'h0, 32'h0, 32'h0};
  logic [31:0] rd5 [5]  = '{32'h0, 32'h55555555, 32'hDEADBEEF, 32'h00000013, 32'h00000013};

  initial begin
    int idx;
    rstn = 1'b0; req = '0; addr = '0; wt = '0; lwe = '0; laddr = '0; lwd = '0;
    tick(); tick();
    req[0] = 1'b1;
    peek();
    chkb("reset gnt forced low", gnt[0], 1'b0);
    chkb("reset rvalid", rv[0], 1'b0);
    chkb("reset proto", pe[0], 1'b0);
    tick();
    req[0] = 1'b0; rstn = 1'b1;

    // preload both memories through the load port
    for (int i = 0; i < 6; i++) begin
      lwe = 2'b11;
      laddr[0] = 32'(i * 4); lwd[0] = pre0[i];
      if (i < 4)       begin laddr[1] = B1 + 32'(i * 4); lwd[1] = pre1[i]; end
      else if (i == 4) begin laddr[1] = B1 + 32'd252;   lwd[1] = 32'hB000003F; end
      else             lwe[1] = 1'b0;
      tick();
    end
    lwe = '0;

    // back-to-back fetches, W=0, latency 1
    for (int k = 0; k < 5; k++) begin
      req[0] = (k < 4); addr[0] = 32'(k * 4);
      peek();
      chkb($sformatf("t1 k%0d gnt", k), gnt[0], k < 4);
      if (k > 0) begin
        chkb($sformatf("t1 k%0d rvalid", k), rv[0], 1'b1);
        chk($sformatf("t1 k%0d rdata", k), rd[0], pre0[k-1]);
        chkb($sformatf("t1 k%0d err", k), er[0], 1'b0);
      end
      tick();
    end

    // W=3; changing wait_cycles_i mid-wait must not matter
    wt[0] = 4'd3;
    for (int k = 0; k < 5; k++) begin
      req[0] = (k < 4); addr[0] = 32'h8;
      if (k == 1) wt[0] = 4'd0;
      peek();
      chkb($sformatf("t2 k%0d gnt", k), gnt[0], k == 3);
      chkb($sformatf("t2 k%0d rvalid", k), rv[0], k == 4);
      if (k == 4) chk("t2 rdata", rd[0], 32'h00200113);
      tick();
    end

    // misaligned and out-of-range errors, then a good fetch
    for (int k = 0; k < 4; k++) begin
      req[0] = (k < 3);
      if (k < 3) addr[0] = a3[k];
      peek();
      chkb($sformatf("t3 k%0d gnt", k), gnt[0], k < 3);
      if (k > 0) begin
        chkb($sformatf("t3 k%0d rvalid", k), rv[0], 1'b1);
        chkb($sformatf("t3 k%0d err", k), er[0], k < 3);
        chk($sformatf("t3 k%0d rdata", k), rd[0], (k == 3) ? 32'h00300193 : 32'h0);
      end
      tick();
    end

    // latency 3, one outstanding: grant once every 3 cycles
    idx = 0;
    for (int k = 0; k < 16; k++) begin
      if (idx < 5) begin req[1] = 1'b1; addr[1] = a4[idx]; end
      else req[1] = 1'b0;
      peek();
      chkb($sformatf("t4 k%0d gnt", k), gnt[1], (k % 3 == 0) && (k <= 12));
      chkb($sformatf("t4 k%0d rvalid", k), rv[1], (k % 3 == 0) && (k >= 3));
      if ((k % 3 == 0) && (k >= 3)) begin
        chkb($sformatf("t4 k%0d err", k), er[1], er4[k/3-1]);
        chk($sformatf("t4 k%0d rdata", k), rd[1], rd4[k/3-1]);
      end
      if (gnt[1]) idx++;
      tick();
    end
    req[1] = 1'b0;

    // load/read collision returns old data; out-of-range load is dropped
    for (int k = 0; k < 5; k++) begin
      req[0] = (k < 4); addr[0] = a5[k];
      lwe[0] = (k == 0) || (k == 2);
      laddr[0] = (k == 0) ? 32'h14 : 32'h4000;
      lwd[0]   = (k == 0) ? 32'hDEADBEEF : 32'hBAD0BAD0;
      peek();
      if (k < 4) chkb($sformatf("t5 k%0d gnt", k), gnt[0], 1'b1);
      if (k > 0) chk($sformatf("t5 k%0d rdata", k), rd[0], rd5[k]);
      tick();
    end
    lwe = '0;

    // drop req while waiting for grant
    wt[0] = 4'd4;
    for (int k = 0; k < 6; k++) begin
      req[0] = (k < 2); addr[0] = 32'h0;
      peek();
      chkb($sformatf("t6 k%0d gnt", k), gnt[0], 1'b0);
      chkb($sformatf("t6 k%0d proto", k), pe[0], k >= 3);
      tick();
    end

    // reset with responses in flight on both instances
    wt[0] = 4'd0;
    req[1] = 1'b1; addr[1] = B1 + 32'd8;
    peek();
    chkb("t7 d1 gnt", gnt[1], 1'b1);
    tick();
    req[1] = 1'b0; req[0] = 1'b1; addr[0] = 32'h8;
    peek();
    chkb("t7 d0 gnt", gnt[0], 1'b1);
    tick();
    rstn = 1'b0;
    peek();
    chkb("t7 rst gnt", gnt[0], 1'b0);
    chkb("t7 rst rvalid0", rv[0], 1'b0);
    chkb("t7 rst proto", pe[0], 1'b0);
    tick();
    rstn = 1'b1; addr[0] = 32'hC;
    peek();
    chkb("t7 post gnt", gnt[0], 1'b1);
    chkb("t7 post rvalid1", rv[1], 1'b0);
    chkb("t7 post proto", pe[0], 1'b0);
    tick();
    req[0] = 1'b0;
    peek();
    chkb("t7 post rvalid0", rv[0], 1'b1);
    chk("t7 post rdata", rd[0], 32'h00300193);
    tick();
    for (int k = 0; k < 4; k++) begin
      peek();
      chkb($sformatf("t7 k%0d quiet0", k), rv[0], 1'b0);
      chkb($sformatf("t7 k%0d quiet1", k), rv[1], 1'b0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
